// File: rtl/keypad_emulator.sv
// keypad_emulator: 4x4 matrix-keypad model. Accepts key-press commands over a
// valid/ready handshake and plays each press as bounce-in, hold, bounce-out and
// gap phases, closing the addressed row/column switch the way a real key does.
module keypad_emulator #(
    parameter int BOUNCE_CYCLES = 8,
    parameter int GAP_CYCLES    = 16
) (
    input  logic        int_osc,
    input  logic        rst,
    input  logic [3:0]  column_signals,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_key,
    input  logic [15:0] cmd_hold,
    output logic [3:0]  row_d,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BOUNCE_IN,
        S_HOLD,
        S_BOUNCE_OUT,
        S_GAP,
        S_DONE
    } state_t;

    // Counter reload values; only used when the matching phase exists.
    localparam logic [15:0] BOUNCE_LOAD = (BOUNCE_CYCLES > 0) ? 16'(BOUNCE_CYCLES - 1) : 16'd0;
    localparam logic [15:0] GAP_LOAD    = (GAP_CYCLES > 0)    ? 16'(GAP_CYCLES - 1)    : 16'd0;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] hold_q, hold_d;
    logic [3:0]  key_q, key_d;
    logic        contact_q, contact_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ready_q, ready_d;
    logic        bounce_d;

    // x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Phase sequencing; every transition reloads cnt so it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        key_d   = key_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    key_d  = cmd_key;
                    hold_d = (cmd_hold == 16'd0) ? 16'd1 : cmd_hold;
                    if (BOUNCE_CYCLES > 0) begin
                        state_d = S_BOUNCE_IN;
                        cnt_d   = BOUNCE_LOAD;
                    end else begin
                        state_d = S_HOLD;
                        cnt_d   = hold_d - 16'd1;
                    end
                end
            end
            S_BOUNCE_IN: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_HOLD;
                    cnt_d   = hold_q - 16'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q == 16'd0) begin
                    if (BOUNCE_CYCLES > 0) begin
                        state_d = S_BOUNCE_OUT;
                        cnt_d   = BOUNCE_LOAD;
                    end else if (GAP_CYCLES > 0) begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_BOUNCE_OUT: begin
                if (cnt_q == 16'd0) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered outputs are decoded from the next state so they line up with
    // the phase they belong to; the LFSR steps once per chatter sample.
    always_comb begin
        bounce_d  = (state_d == S_BOUNCE_IN) || (state_d == S_BOUNCE_OUT);
        contact_d = (state_d == S_HOLD) || (bounce_d && lfsr_q[0]);
        lfsr_d    = bounce_d ? lfsr_next(lfsr_q) : lfsr_q;
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        ready_d   = (state_d == S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge int_osc) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            hold_q    <= 16'd0;
            key_q     <= 4'd0;
            contact_q <= 1'b0;
            lfsr_q    <= 8'hA5;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            key_q     <= key_d;
            contact_q <= contact_d;
            lfsr_q    <= lfsr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    // Passive switch matrix: the closed key ties its column to its row.
    always_comb begin
        row_d             = 4'b0000;
        row_d[key_q[3:2]] = contact_q & column_signals[key_q[1:0]];
    end

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed checks of two emulator instances, one without
// bounce (short gap) and one with the default bounce/gap timing.
module tb_keypad_emulator;

    logic int_osc = 1'b0;
    always #5 int_osc = ~int_osc;

    // Instance A: BOUNCE_CYCLES = 0, GAP_CYCLES = 2
    logic        rst_a, cmd_valid_a, cmd_ready_a, busy_a, done_a;
    logic [3:0]  col_a, cmd_key_a, row_a;
    logic [15:0] cmd_hold_a;
    // Instance B: BOUNCE_CYCLES = 8, GAP_CYCLES = 16
    logic        rst_b, cmd_valid_b, cmd_ready_b, busy_b, done_b;
    logic [3:0]  col_b, cmd_key_b, row_b;
    logic [15:0] cmd_hold_b;

    keypad_emulator #(.BOUNCE_CYCLES(0), .GAP_CYCLES(2)) u_a (
        .int_osc(int_osc), .rst(rst_a), .column_signals(col_a),
        .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a), .cmd_key(cmd_key_a),
        .cmd_hold(cmd_hold_a), .row_d(row_a), .busy(busy_a), .done(done_a)
    );

    keypad_emulator #(.BOUNCE_CYCLES(8), .GAP_CYCLES(16)) u_b (
        .int_osc(int_osc), .rst(rst_b), .column_signals(col_b),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_key(cmd_key_b),
        .cmd_hold(cmd_hold_b), .row_d(row_b), .busy(busy_b), .done(done_b)
    );

    typedef struct {
        logic [3:0] col;
        logic [3:0] exp_row;
    } scan_vec_t;

    scan_vec_t scan_tbl[8];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic tick();
        @(posedge int_osc);
        #1;
    endtask

    // Present a command for one edge; the emulator must be idle when called.
    task automatic issue_a(input logic [3:0] key, input logic [15:0] hold);
        cmd_key_a   = key;
        cmd_hold_a  = hold;
        cmd_valid_a = 1'b1;
        tick();
        cmd_valid_a = 1'b0;
    endtask

    task automatic issue_b(input logic [3:0] key, input logic [15:0] hold);
        cmd_key_b   = key;
        cmd_hold_b  = hold;
        cmd_valid_b = 1'b1;
        tick();
        cmd_valid_b = 1'b0;
    endtask

    initial begin
        int row_bad, busy_cnt, done_cnt, done_at, ready_bad;
        int bi_bad, hold_bad, bo_bad, gap_bad;
        logic [7:0] m;
        logic [3:0] exp_row;

        scan_tbl[0] = '{4'b0001, 4'b0000};
        scan_tbl[1] = '{4'b0010, 4'b0000};
        scan_tbl[2] = '{4'b0100, 4'b0000};
        scan_tbl[3] = '{4'b1000, 4'b1000};
        scan_tbl[4] = '{4'b1111, 4'b1000};
        scan_tbl[5] = '{4'b0111, 4'b0000};
        scan_tbl[6] = '{4'b0000, 4'b0000};
        scan_tbl[7] = '{4'b1001, 4'b1000};

        // ---------------- reset with cmd_valid held high
        rst_a = 1'b1; rst_b = 1'b1;
        col_a = 4'b1111; col_b = 4'b1111;
        cmd_valid_a = 1'b1; cmd_key_a = 4'b0101; cmd_hold_a = 16'd3;
        cmd_valid_b = 1'b1; cmd_key_b = 4'b0101; cmd_hold_b = 16'd3;
        for (int k = 0; k < 2; k++) begin
            tick();
            @(negedge int_osc);
            chk("reset_row_a", 32'(row_a), 32'h0);
            chk("reset_busy_a", 32'(busy_a), 32'h0);
            chk("reset_ready_a", 32'(cmd_ready_a), 32'h1);
            chk("reset_row_b", 32'(row_b), 32'h0);
        end
        tick();
        rst_a = 1'b0; rst_b = 1'b0;
        cmd_valid_a = 1'b0; cmd_valid_b = 1'b0;
        tick();
        @(negedge int_osc);
        chk("no_accept_in_reset_a", 32'(busy_a), 32'h0);
        chk("no_accept_in_reset_b", 32'(busy_b), 32'h0);

        // ---------------- clean press: key row1/col2, hold 5
        col_a = 4'b0100;
        issue_a(4'b0110, 16'd5);
        row_bad = 0; busy_cnt = 0; done_cnt = 0; done_at = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge int_osc);
            exp_row = (k <= 5) ? 4'b0010 : 4'b0000;
            if (row_a !== exp_row) row_bad++;
            if (busy_a) busy_cnt++;
            if (done_a) begin done_cnt++; done_at = k; end
        end
        chk("clean_row_pattern_bad_cycles", 32'(row_bad), 32'd0);
        chk("clean_busy_cycles", 32'(busy_cnt), 32'd8);
        chk("clean_done_count", 32'(done_cnt), 32'd1);
        chk("clean_done_cycle", 32'(done_at), 32'd8);

        // ---------------- cmd_hold = 0 behaves as 1
        issue_a(4'b0110, 16'd0);
        row_bad = 0; busy_cnt = 0; done_at = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge int_osc);
            exp_row = (k == 1) ? 4'b0010 : 4'b0000;
            if (row_a !== exp_row) row_bad++;
            if (busy_a) busy_cnt++;
            if (done_a) done_at = k;
        end
        chk("hold0_row_bad_cycles", 32'(row_bad), 32'd0);
        chk("hold0_busy_cycles", 32'(busy_cnt), 32'd4);
        chk("hold0_done_cycle", 32'(done_at), 32'd4);

        // ---------------- back-to-back with cmd_valid held high
        col_a       = 4'b0110;
        cmd_key_a   = 4'b0001;
        cmd_hold_a  = 16'd3;
        cmd_valid_a = 1'b1;
        tick();
        ready_bad = 0; done_at = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge int_osc);
            if (k <= 6 && cmd_ready_a !== 1'b0) ready_bad++;
            if (k == 1) begin
                chk("b2b_first_row", 32'(row_a), 32'h1);
                cmd_key_a  = 4'b1010;
                cmd_hold_a = 16'd2;
            end
            if (k <= 7 && done_a) done_at = k;
            if (k == 7) begin
                chk("b2b_ready_after_done", 32'(cmd_ready_a), 32'h1);
                chk("b2b_idle_after_done", 32'(busy_a), 32'h0);
            end
            if (k == 8) begin
                chk("b2b_second_busy", 32'(busy_a), 32'h1);
                chk("b2b_second_row", 32'(row_a), 32'h4);
                cmd_valid_a = 1'b0;
            end
            if (k == 12) chk("b2b_second_done", 32'(done_a), 32'h1);
        end
        chk("b2b_ready_low_during_first", 32'(ready_bad), 32'd0);
        chk("b2b_first_done_cycle", 32'(done_at), 32'd6);

        // ---------------- scan interaction during a long hold of key 1111
        issue_a(4'b1111, 16'd100);
        for (int i = 0; i < 8; i++) begin
            col_a = scan_tbl[i].col;
            @(negedge int_osc);
            chk($sformatf("scan_row_col%b", scan_tbl[i].col), 32'(row_a), 32'(scan_tbl[i].exp_row));
            tick();
        end

        // ---------------- reset mid-HOLD on A
        col_a = 4'b1000;
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        @(negedge int_osc);
        chk("midrst_a_row", 32'(row_a), 32'h0);
        chk("midrst_a_busy", 32'(busy_a), 32'h0);
        chk("midrst_a_ready", 32'(cmd_ready_a), 32'h1);
        done_cnt = 0; busy_cnt = 0;
        for (int k = 0; k < 120; k++) begin
            @(negedge int_osc);
            if (done_a) done_cnt++;
            if (busy_a) busy_cnt++;
        end
        chk("midrst_a_no_done", 32'(done_cnt), 32'd0);
        chk("midrst_a_stays_idle", 32'(busy_cnt), 32'd0);

        // ---------------- bounce press on B: key 0000, hold 4
        col_b = 4'b0001;
        m = 8'hA5;
        issue_b(4'b0000, 16'd4);
        bi_bad = 0; hold_bad = 0; bo_bad = 0; gap_bad = 0; busy_cnt = 0; done_at = 0;
        for (int k = 1; k <= 42; k++) begin
            @(negedge int_osc);
            if (k <= 8) begin
                if (row_b !== {3'b000, m[0]}) bi_bad++;
                m = ref_lfsr_step(m);
            end else if (k <= 12) begin
                if (row_b !== 4'b0001) hold_bad++;
            end else if (k <= 20) begin
                if (row_b !== {3'b000, m[0]}) bo_bad++;
                m = ref_lfsr_step(m);
            end else begin
                if (row_b !== 4'b0000) gap_bad++;
            end
            if (busy_b) busy_cnt++;
            if (done_b) done_at = k;
        end
        chk("bounce_in_chatter_bad", 32'(bi_bad), 32'd0);
        chk("bounce_hold_bad", 32'(hold_bad), 32'd0);
        chk("bounce_out_chatter_bad", 32'(bo_bad), 32'd0);
        chk("bounce_gap_bad", 32'(gap_bad), 32'd0);
        chk("bounce_busy_cycles", 32'(busy_cnt), 32'd37);
        chk("bounce_done_cycle", 32'(done_at), 32'd37);

        // ---------------- reset mid-HOLD on B, then chatter restarts from seed
        issue_b(4'b0000, 16'd50);
        for (int k = 0; k < 12; k++) tick();
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        @(negedge int_osc);
        chk("midrst_b_row", 32'(row_b), 32'h0);
        chk("midrst_b_busy", 32'(busy_b), 32'h0);
        done_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge int_osc);
            if (done_b) done_cnt++;
        end
        chk("midrst_b_no_done", 32'(done_cnt), 32'd0);
        m = 8'hA5;
        bi_bad = 0;
        issue_b(4'b0000, 16'd1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge int_osc);
            if (row_b !== {3'b000, m[0]}) bi_bad++;
            m = ref_lfsr_step(m);
        end
        chk("midrst_b_lfsr_reseeded", 32'(bi_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Synthesizable 4x4 matrix-keypad model that answers the column scan of the keypad scanner by driving the row lines as a physical switch would. It accepts key-press commands over a valid/ready handshake and plays each press as bounce-in, hold, bounce-out and gap phases, with pseudo-random contact chatter during bounce. It sits opposite the scanner/debouncer on the row/column interface and is used for hardware-in-loop and regression checking of the scan path.

## Interface
- BOUNCE_CYCLES, 8: length of each bounce phase in int_osc cycles; 0 skips both bounce phases.
- GAP_CYCLES, 16: forced-release time after bounce-out, before the next command is accepted; 0 skips the gap.
- int_osc  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- column_signals  in  4  column drive from the scanner; active-high; normally one-hot, but any pattern is legal.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  emulator can accept a command.
- cmd_key  in  4  key code {row[1:0], col[1:0]}.
- cmd_hold  in  16  stable-contact duration in cycles; 0 is treated as 1.
- row_d  out  4  row lines returned to the scanner; active-high.
- busy  out  1  a press is in progress (any state other than IDLE).
- done  out  1  single-cycle pulse when a press sequence completes.

## Operation
- States: IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP, DONE.
- Registers:
  - key_r[3:0] holds the accepted key.
  - cnt[15:0] is the phase down-counter.
  - contact is a 1-bit switch-closed flag.
  - lfsr[7:0] is the chatter source.
- IDLE:
  - cmd_ready = 1 and contact = 0.
  - On cmd_valid & cmd_ready: latch key_r = cmd_key and hold_r = max(cmd_hold, 1).
  - Go to BOUNCE_IN with cnt = BOUNCE_CYCLES-1. If BOUNCE_CYCLES = 0, go directly to HOLD with cnt = hold_r-1.
- BOUNCE_IN:
  - contact = lfsr[0] each cycle.
  - When cnt = 0, go to HOLD with cnt = hold_r-1. Otherwise decrement cnt.
- HOLD:
  - contact = 1.
  - When cnt = 0, go to BOUNCE_OUT with cnt = BOUNCE_CYCLES-1. If BOUNCE_CYCLES = 0, go to GAP, or to DONE if GAP_CYCLES = 0.
- BOUNCE_OUT:
  - contact = lfsr[0].
  - When cnt = 0, go to GAP with cnt = GAP_CYCLES-1, or to DONE if GAP_CYCLES = 0.
- GAP:
  - contact = 0.
  - When cnt = 0, go to DONE.
- DONE:
  - done = 1 and contact = 0 for one cycle, then IDLE.
- Row drive is combinational from registered state and the live columns: row_d[key_r[3:2]] = contact & column_signals[key_r[1:0]]. All other row bits are 0.
- LFSR:
  - Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Shifts left; feedback = lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3] enters at bit 0.
  - Seed is 8'hA5 on reset.
  - Advances only in the cycles it is sampled (BOUNCE_IN and BOUNCE_OUT) and holds otherwise, so chatter is reproducible.
- cmd_ready = (state == IDLE). Commands presented while busy are not accepted; the initiator holds cmd_valid.
- Only one key is modeled at a time; simultaneous multi-key presses are out of scope.

## Timing
- Reset values, applied on the first int_osc edge with rst = 1 and independent of state:
  - state = IDLE, contact = 0, cnt = 0, key_r = 0, lfsr = 8'hA5.
  - Outputs: row_d = 0, busy = 0, done = 0, cmd_ready = 1 (since state = IDLE).
- Reset mid-press: row_d is 0 in the cycle after the reset edge, no done pulse is emitted, and the press is discarded.
- Handshake: the command is accepted on the edge where cmd_valid & cmd_ready = 1. busy rises and cmd_ready falls on the following cycle.
- Column-to-row path is zero-latency (combinational), matching a passive switch matrix. The scanner sees row_d change in the same cycle its column changes.
- Phase lengths in cycles, counted from the first cycle in that state:
  - BOUNCE_IN = BOUNCE_CYCLES.
  - HOLD = hold_r.
  - BOUNCE_OUT = BOUNCE_CYCLES.
  - GAP = GAP_CYCLES.
  - DONE = 1.
- Total busy time = 2*BOUNCE_CYCLES + hold_r + GAP_CYCLES + 1. The next command can be accepted in the cycle after DONE.
- cnt is 16 bits wide, so hold_r ranges 1..65535. cnt never wraps: every transition reloads it.

## Test plan
- Reset: hold rst = 1 for 2 cycles with cmd_valid = 1 -> row_d = 0, busy = 0, cmd_ready = 1, no command accepted during reset.
- Clean press:
  - Setup: BOUNCE_CYCLES = 0, GAP_CYCLES = 2; key 4'b0110 (row 1, col 2), hold 5; scanner drives column_signals = 4'b0100.
  - Required: row_d = 4'b0010 for exactly 5 cycles, then 0.
  - Required: done pulses once, 8 cycles after acceptance, and busy spans 8 cycles.
- Scan interaction: during HOLD of key 4'b1111, rotate column_signals through 0001, 0010, 0100, 1000 -> row_d = 4'b1000 only while column_signals[3] = 1, otherwise 0.
- Bounce:
  - Setup: BOUNCE_CYCLES = 8, key 4'b0000, column_signals = 4'b0001.
  - Required: row_d[0] during BOUNCE_IN follows lfsr[0] starting from seed 8'hA5, matching a reference LFSR model bit for bit. It is solid 1 during HOLD.
- Back-to-back: keep cmd_valid high with two commands -> the second is accepted exactly 1 cycle after done, and cmd_ready = 0 throughout the first press.
- Boundary:
  - cmd_hold = 0 -> HOLD lasts 1 cycle.
  - rst asserted mid-HOLD -> row_d = 0 and busy = 0 on the next cycle, no done pulse, and lfsr returns to 8'hA5.
